// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// A valid/ready handshake allows back-to-back frames with no idle gap.
module uart_tx_frame #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic                 baud_clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 o_ready,
  output logic                 o_busy,
  output logic                 o_bit
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_BITS - 1);
  localparam logic            StopLast = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 parity_q, parity_d;
  logic                 bit_q, bit_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 bit_end, accept, load;

  always_comb begin
    state_d    = state_q;
    bit_end    = (bit_cnt_q == CntLast);
    bit_cnt_d  = bit_end ? '0 : bit_cnt_q + CntW'(1);
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    shreg_d    = shreg_q;
    parity_d   = parity_q;
    accept     = data_valid && ready_q;
    load       = 1'b0;

    unique case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        load      = accept;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == IdxLast) begin
            state_d    = (PARITY != 0) ? StParity : StStop;
            stop_cnt_d = 1'b0;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d    = StStop;
          stop_cnt_d = 1'b0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop_cnt_q == StopLast) begin
            // ready_q is high exactly here, so accept means a seamless next frame
            state_d = StIdle;
            load    = accept;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      state_d   = StStart;
      bit_cnt_d = '0;
      shreg_d   = data_in;
      parity_d  = (PARITY == 1) ? ~^data_in : ((PARITY == 2) ? ^data_in : 1'b0);
    end

    // Outputs are registered from next-state values so they align with the state.
    bit_d = 1'b1;
    unique case (state_d)
      StStart:  bit_d = 1'b0;
      StData:   bit_d = shreg_d[0];
      StParity: bit_d = parity_d;
      default:  bit_d = 1'b1;
    endcase
    busy_d  = (state_d != StIdle);
    ready_d = (state_d == StIdle) ||
              ((state_d == StStop) && (stop_cnt_d == StopLast) && (bit_cnt_d == CntLast));
  end

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      idx_q      <= '0;
      stop_cnt_q <= 1'b0;
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      bit_q      <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      idx_q      <= idx_d;
      stop_cnt_q <= stop_cnt_d;
      shreg_q    <= shreg_d;
      parity_q   <= parity_d;
      bit_q      <= bit_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign o_bit   = bit_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations checked clock-by-clock against a
// frame-level model of the serial line, ready and busy.
module tb_uart_tx_frame;

  logic       clk;
  logic       rst;
  logic [2:0] dv;
  logic [2:0] ob;
  logic [2:0] ordy;
  logic [2:0] obsy;
  logic [7:0] din0;
  logic [7:0] din1;
  logic [4:0] din2;

  int checks;
  int errors;

  // Per-unit configuration: data bits, parity mode, stop bits, clocks per bit.
  int cfg_db  [3] = '{8, 8, 5};
  int cfg_par [3] = '{2, 1, 0};
  int cfg_sb  [3] = '{1, 2, 1};
  int cfg_cpb [3] = '{4, 3, 1};

  logic [8:0] words_q[$];
  bit         exp_bit[$];
  bit         exp_first[$];
  bit         exp_last[$];

  uart_tx_frame #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(4)) u_dut_even (
    .baud_clk(clk), .rst(rst), .data_in(din0), .data_valid(dv[0]),
    .o_ready(ordy[0]), .o_busy(obsy[0]), .o_bit(ob[0])
  );

  uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .CLKS_PER_BIT(3)) u_dut_odd (
    .baud_clk(clk), .rst(rst), .data_in(din1), .data_valid(dv[1]),
    .o_ready(ordy[1]), .o_busy(obsy[1]), .o_bit(ob[1])
  );

  uart_tx_frame #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(1)) u_dut_narrow (
    .baud_clk(clk), .rst(rst), .data_in(din2), .data_valid(dv[2]),
    .o_ready(ordy[2]), .o_busy(obsy[2]), .o_bit(ob[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_din(input int u, input logic [8:0] w);
    case (u)
      0:       din0 = w[7:0];
      1:       din1 = w[7:0];
      default: din2 = w[4:0];
    endcase
  endtask

  // Line model: a frame is a list of bit values, each stretched to cpb clocks.
  task automatic add_frame(input int u, input logic [8:0] w);
    bit fb[$];
    int ones;
    ones = 0;
    fb.push_back(1'b0);
    for (int i = 0; i < cfg_db[u]; i++) begin
      fb.push_back(w[i]);
      ones += int'(w[i]);
    end
    if (cfg_par[u] == 1) fb.push_back((ones % 2) == 0);
    if (cfg_par[u] == 2) fb.push_back((ones % 2) == 1);
    for (int i = 0; i < cfg_sb[u]; i++) fb.push_back(1'b1);
    for (int j = 0; j < fb.size(); j++) begin
      for (int c = 0; c < cfg_cpb[u]; c++) begin
        exp_bit.push_back(fb[j]);
        exp_first.push_back(j == 0 && c == 0);
        exp_last.push_back(j == fb.size() - 1 && c == cfg_cpb[u] - 1);
      end
    end
  endtask

  // Sends words_q on unit u with data_valid held while words remain.
  // abort_at >= 0 asserts reset after that frame clock.
  task automatic run(input int u, input int abort_at);
    int nxt;
    exp_bit.delete();
    exp_first.delete();
    exp_last.delete();
    foreach (words_q[i]) add_frame(u, words_q[i]);
    @(negedge clk);
    checks++;
    if ({ob[u], ordy[u], obsy[u]} !== 3'b110) begin
      errors++;
      $display("FAIL pre_idle u=%0d got bit/ready/busy=%b want 110", u, {ob[u], ordy[u], obsy[u]});
    end
    set_din(u, words_q[0]);
    dv[u] = 1'b1;
    nxt = 1;
    for (int k = 0; k < exp_bit.size(); k++) begin
      @(negedge clk);
      checks++;
      if ({ob[u], ordy[u], obsy[u]} !== {exp_bit[k], exp_last[k], 1'b1}) begin
        errors++;
        $display("FAIL frame u=%0d clk=%0d got bit/ready/busy=%b want %b", u, k,
                 {ob[u], ordy[u], obsy[u]}, {exp_bit[k], exp_last[k], 1'b1});
      end
      if (exp_first[k]) begin
        if (nxt < words_q.size()) begin
          set_din(u, words_q[nxt]);
          nxt++;
        end else begin
          dv[u] = 1'b0;
          set_din(u, 9'($urandom));
        end
      end
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ob[u], ordy[u], obsy[u]} !== 3'b110) begin
          errors++;
          $display("FAIL mid_reset u=%0d got bit/ready/busy=%b want 110", u,
                   {ob[u], ordy[u], obsy[u]});
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
          @(negedge clk);
          checks++;
          if ({ob[u], ordy[u], obsy[u]} !== 3'b110) begin
            errors++;
            $display("FAIL post_reset u=%0d clk=%0d got bit/ready/busy=%b want 110", u, i,
                     {ob[u], ordy[u], obsy[u]});
          end
        end
        return;
      end
    end
    @(negedge clk);
    checks++;
    if ({ob[u], ordy[u], obsy[u]} !== 3'b110) begin
      errors++;
      $display("FAIL post_idle u=%0d got bit/ready/busy=%b want 110", u, {ob[u], ordy[u], obsy[u]});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dv  = 3'b111;
    set_din(0, 9'h0A5);
    set_din(1, 9'h000);
    set_din(2, 9'h013);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
        checks++;
        if ({ob[u], ordy[u], obsy[u]} !== 3'b110) begin
          errors++;
          $display("FAIL reset u=%0d clk=%0d got bit/ready/busy=%b want 110", u, i,
                   {ob[u], ordy[u], obsy[u]});
        end
      end
    end
    rst = 1'b0;
    dv  = 3'b000;
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      checks++;
      if ({ob[u], ordy[u], obsy[u]} !== 3'b110) begin
        errors++;
        $display("FAIL reset_release u=%0d got bit/ready/busy=%b want 110", u,
                 {ob[u], ordy[u], obsy[u]});
      end
    end
  endtask

  task automatic test_even_parity();
    words_q = '{9'h0A5};
    run(0, -1);
    for (int i = 0; i < 3; i++) begin
      words_q = '{9'($urandom)};
      run(0, -1);
    end
  endtask

  task automatic test_odd_two_stop();
    words_q = '{9'h000};
    run(1, -1);
    for (int i = 0; i < 3; i++) begin
      words_q = '{9'($urandom)};
      run(1, -1);
    end
  endtask

  task automatic test_back_to_back();
    words_q = '{9'h055, 9'h00F};
    run(0, -1);
    words_q = '{9'($urandom), 9'($urandom), 9'($urandom)};
    run(1, -1);
  endtask

  task automatic test_mid_reset();
    // Clock 13 of a CPB=4 frame lies in the third data bit.
    words_q = '{9'h0FF};
    run(0, 13);
    words_q = '{9'($urandom)};
    run(0, -1);
  endtask

  task automatic test_narrow();
    words_q = '{9'h013};
    run(2, -1);
    words_q = '{9'h1F3, 9'($urandom), 9'($urandom), 9'($urandom)};
    run(2, -1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    dv     = 3'b000;
    din0   = '0;
    din1   = '0;
    din2   = '0;
    test_reset();
    test_even_parity();
    test_odd_two_stop();
    test_back_to_back();
    test_mid_reset();
    test_narrow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
